// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: default datapath widths,
// the reset PC and the fetch-queue entry layout.
package mips_pkg;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef struct packed {
      logic [DEF_AW-1:0] pc;
      logic [DEF_DW-1:0] data;
      logic              filled;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_entry_ram.sv
// Fetch-queue storage: one register per entry field, written by an allocate
// port (address) and a fill port (instruction), read at the head index.
module ifetch_entry_ram #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          alloc_en,
   input  logic [IW-1:0] alloc_idx,
   input  logic [AW-1:0] alloc_pc,
   input  logic          fill_en,
   input  logic [IW-1:0] fill_idx,
   input  logic [DW-1:0] fill_data,
   input  logic [IW-1:0] rd_idx,
   output logic [AW-1:0] rd_pc,
   output logic [DW-1:0] rd_data,
   output logic          rd_filled
);

   logic [AW-1:0]    pc_q   [DEPTH];
   logic [AW-1:0]    pc_d   [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [DEPTH-1:0] filled_d;

   // Per-entry next state; clear only drops the filled flags, stale fields stay visible
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pc_d[i]     = (alloc_en && (alloc_idx == IW'(i))) ? alloc_pc : pc_q[i];
         data_d[i]   = (fill_en && (fill_idx == IW'(i))) ? fill_data : data_q[i];
         filled_d[i] = clear ? 1'b0 :
                       (alloc_en && (alloc_idx == IW'(i))) ? 1'b0 :
                       (fill_en && (fill_idx == IW'(i))) ? 1'b1 : filled_q[i];
      end
   end

   // Entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= '{default: '0};
         data_q   <= '{default: '0};
         filled_q <= '0;
      end else begin
         pc_q     <= pc_d;
         data_q   <= data_d;
         filled_q <= filled_d;
      end
   end

   assign rd_pc     = pc_q[rd_idx];
   assign rd_data   = data_q[rd_idx];
   assign rd_filled = filled_q[rd_idx];

endmodule

// File: rtl/ifetch_queue_chk.sv
// Simulation checker for the instruction-memory response protocol.
module ifetch_queue_chk #(
   parameter int CW = 3
) (
   input logic          clk,
   input logic          rst_n,
   input logic          rvalid,
   input logic [CW-1:0] pend,
   input logic [CW-1:0] drop
);

   // Every response must match either a pending fetch or one marked for discard
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      rvalid |-> ((pend != '0) || (drop != '0)))
      else $error("ifetch_queue: response with nothing outstanding");

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues PC values to instruction memory, pairs the
// in-order read data with its address and presents it to decode.
module ifetch_queue import mips_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic          Clk,
   input  logic          ReSet_n,
   input  logic          PcValid,
   input  logic [AW-1:0] PC,
   output logic          PcReady,
   input  logic          Flush,
   output logic          ImemReq,
   output logic [AW-1:0] ImemAddr,
   input  logic          ImemGnt,
   input  logic          ImemRvalid,
   input  logic [DW-1:0] ImemRdata,
   output logic          InstrValid,
   output logic [DW-1:0] Instr,
   output logic [AW-1:0] InstrPC,
   input  logic          InstrReady
);

   localparam int             IW      = $clog2(DEPTH);
   localparam int             CW      = IW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   logic [IW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
   logic [CW-1:0] occ_q, occ_d, pend_q, pend_d, drop_q, drop_d;
   logic [CW-1:0] drop_sum_s;

   logic          req_s, grant_s, resp_fill_s, resp_drop_s, valid_s, pop_s;
   logic [AW-1:0] rd_pc_s;
   logic [DW-1:0] rd_data_s;
   logic          rd_filled_s;

   // Handshake decode; occ is used before any same-cycle pop, so a full queue never bypasses
   always_comb begin
      req_s       = ReSet_n & PcValid & ~Flush & (drop_q == '0) & (occ_q < DEPTH_C);
      grant_s     = req_s & ImemGnt;
      resp_fill_s = ImemRvalid & ~Flush & (drop_q == '0) & (pend_q != '0);
      resp_drop_s = ImemRvalid & (drop_q != '0);
      valid_s     = rd_filled_s & (occ_q != '0) & ~Flush;
      pop_s       = valid_s & InstrReady;
   end

   // Pointer and counter update; a flush turns everything in flight into discards
   always_comb begin
      drop_sum_s = drop_q + pend_q;
      if (Flush) begin
         head_d = '0;
         fill_d = '0;
         tail_d = '0;
         occ_d  = '0;
         pend_d = '0;
         drop_d = drop_sum_s - CW'(ImemRvalid && (drop_sum_s != '0));
      end else begin
         head_d = head_q + IW'(pop_s);
         fill_d = fill_q + IW'(resp_fill_s);
         tail_d = tail_q + IW'(grant_s);
         occ_d  = occ_q + CW'(grant_s) - CW'(pop_s);
         pend_d = pend_q + CW'(grant_s) - CW'(resp_fill_s);
         drop_d = drop_q - CW'(resp_drop_s);
      end
   end

   // Queue control registers
   always_ff @(posedge Clk or negedge ReSet_n) begin
      if (!ReSet_n) begin
         head_q <= '0;
         fill_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         pend_q <= '0;
         drop_q <= '0;
      end else begin
         head_q <= head_d;
         fill_q <= fill_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end

   ifetch_entry_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .IW    (IW)
   ) u_ram (
      .clk       (Clk),
      .rst_n     (ReSet_n),
      .clear     (Flush),
      .alloc_en  (grant_s),
      .alloc_idx (tail_q),
      .alloc_pc  (PC),
      .fill_en   (resp_fill_s),
      .fill_idx  (fill_q),
      .fill_data (ImemRdata),
      .rd_idx    (head_q),
      .rd_pc     (rd_pc_s),
      .rd_data   (rd_data_s),
      .rd_filled (rd_filled_s)
   );

   ifetch_queue_chk #(.CW(CW)) u_chk (
      .clk    (Clk),
      .rst_n  (ReSet_n),
      .rvalid (ImemRvalid),
      .pend   (pend_q),
      .drop   (drop_q)
   );

   assign ImemReq    = req_s;
   assign ImemAddr   = PC;
   assign PcReady    = grant_s;
   assign InstrValid = valid_s;
   assign Instr      = rd_data_s;
   assign InstrPC    = rd_pc_s;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: PC-unit and 1-cycle memory models, with a scoreboard
// of expected (pc, instruction) pairs pushed at grant and popped at decode.
module tb_ifetch_queue;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        Clk = 1'b0;
   logic        ReSet_n;
   logic        PcValid;
   logic [31:0] PC;
   logic        PcReady;
   logic        Flush;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemGnt;
   logic        ImemRvalid;
   logic [31:0] ImemRdata;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrReady;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   logic        mem_stall = 1'b0;
   int          remaining = 0;
   int          cyc = 0;
   int          n_grants = 0;
   int          n_pops = 0;
   int          grant_cyc = 0;
   int          first_valid_cyc = -1;
   int          win_first_pop = -1;
   int          last_pop_cyc = 0;
   logic [31:0] last_pop_pc = '0;
   logic [31:0] last_pop_instr = '0;
   logic        last_req = 1'b0;
   logic        valid_seen = 1'b0;

   always #5 Clk = ~Clk;

   ifetch_queue dut (
      .Clk        (Clk),
      .ReSet_n    (ReSet_n),
      .PcValid    (PcValid),
      .PC         (PC),
      .PcReady    (PcReady),
      .Flush      (Flush),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .ImemGnt    (ImemGnt),
      .ImemRvalid (ImemRvalid),
      .ImemRdata  (ImemRdata),
      .InstrValid (InstrValid),
      .Instr      (Instr),
      .InstrPC    (InstrPC),
      .InstrReady (InstrReady)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] addr);
      if (addr == 32'h0000_3000) return 32'h2008_0005;
      else return {~addr[15:0], addr[15:0]};
   endfunction

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_fetch(input logic [31:0] addr, input int n);
      PC        = addr;
      remaining = n;
      PcValid   = (n > 0);
   endtask

   // One clock: drive memory response, sample at negedge, advance PC after posedge
   task automatic cycle();
      logic adv;
      exp_t e;
      adv = 1'b0;
      if (!mem_stall && mem_q.size() > 0) begin
         ImemRvalid = 1'b1;
         ImemRdata  = mem_data(mem_q.pop_front());
      end else begin
         ImemRvalid = 1'b0;
         ImemRdata  = 32'h0;
      end
      @(negedge Clk);
      last_req = ImemReq;
      if (ReSet_n) begin
         if (Flush) exp_q.delete();
         if (ImemReq && ImemGnt) begin
            mem_q.push_back(PC);
            exp_q.push_back('{pc: PC, data: mem_data(PC)});
            n_grants++;
            grant_cyc = cyc;
            adv = 1'b1;
         end
         if (InstrValid) begin
            valid_seen = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (InstrValid && InstrReady) begin
            if (exp_q.size() == 0) begin
               chk_eq("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk_eq("sb_instr", {32'h0, Instr}, {32'h0, e.data});
               chk_eq("sb_pc", {32'h0, InstrPC}, {32'h0, e.pc});
            end
            n_pops++;
            if (win_first_pop < 0) win_first_pop = cyc;
            last_pop_cyc   = cyc;
            last_pop_pc    = InstrPC;
            last_pop_instr = Instr;
         end
      end
      @(posedge Clk);
      #1;
      cyc++;
      if (adv) begin
         PC = PC + 32'd4;
         remaining--;
         PcValid = (remaining > 0);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int i;
      i = 0;
      while ((remaining > 0 || exp_q.size() > 0 || mem_q.size() > 0) && i < budget) begin
         cycle();
         i++;
      end
      chk_eq(tag, {63'd0, (remaining > 0 || exp_q.size() > 0 || mem_q.size() > 0)}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, g0;
      ReSet_n    = 1'b1;
      PcValid    = 1'b1;
      PC         = 32'h0000_3000;
      Flush      = 1'b0;
      ImemGnt    = 1'b1;
      ImemRvalid = 1'b0;
      ImemRdata  = 32'h0;
      InstrReady = 1'b1;
      #2 ReSet_n = 1'b0;
      #1;
      chk_eq("rst_imemreq", {63'd0, ImemReq}, 64'd0);
      chk_eq("rst_pcready", {63'd0, PcReady}, 64'd0);
      chk_eq("rst_instrvalid", {63'd0, InstrValid}, 64'd0);
      chk_eq("rst_instr", {32'h0, Instr}, 64'd0);
      chk_eq("rst_instrpc", {32'h0, InstrPC}, 64'd0);
      chk_eq("rst_occ", 64'(dut.occ_q), 64'd0);
      cycle();
      cycle();
      PcValid = 1'b0;
      ReSet_n = 1'b1;
      cycle();

      // Single fetch: latency grant -> InstrValid is two cycles
      first_valid_cyc = -1;
      p0 = n_pops;
      set_fetch(32'h0000_3000, 1);
      for (int i = 0; i < 10 && n_pops == p0; i++) cycle();
      chk_eq("t1_latency", 64'(first_valid_cyc - grant_cyc), 64'd2);
      chk_eq("t1_instr", {32'h0, last_pop_instr}, 64'h2008_0005);
      chk_eq("t1_pc", {32'h0, last_pop_pc}, 64'h3000);

      // Streaming eight fetches at one per cycle
      p0 = n_pops;
      win_first_pop = -1;
      set_fetch(32'h0000_3000, 8);
      drain("t2_drain", 40);
      chk_eq("t2_count", 64'(n_pops - p0), 64'd8);
      chk_eq("t2_rate", 64'(last_pop_cyc - win_first_pop), 64'd7);
      chk_eq("t2_last_pc", {32'h0, last_pop_pc}, 64'h301C);

      // Decode stalled: queue fills after four grants, one pop frees one slot
      InstrReady = 1'b0;
      g0 = n_grants;
      set_fetch(32'h0000_3100, 8);
      for (int i = 0; i < 10; i++) cycle();
      chk_eq("t3_grants", 64'(n_grants - g0), 64'd4);
      chk_eq("t3_full_req", {63'd0, last_req}, 64'd0);
      InstrReady = 1'b1;
      cycle();
      chk_eq("t3_pop_cycle_req", {63'd0, last_req}, 64'd0);
      InstrReady = 1'b0;
      cycle();
      chk_eq("t3_next_req", {63'd0, last_req}, 64'd1);
      cycle();
      chk_eq("t3_refull_req", {63'd0, last_req}, 64'd0);
      chk_eq("t3_grants2", 64'(n_grants - g0), 64'd5);
      InstrReady = 1'b1;
      drain("t3_drain", 40);

      // Flush with two fetches in flight: both responses discarded
      mem_stall = 1'b1;
      set_fetch(32'h0000_3200, 2);
      cycle();
      cycle();
      chk_eq("t4_pend", 64'(dut.pend_q), 64'd2);
      Flush = 1'b1;
      valid_seen = 1'b0;
      cycle();
      Flush = 1'b0;
      chk_eq("t4_drop", 64'(dut.drop_q), 64'd2);
      mem_stall = 1'b0;
      set_fetch(32'h0000_3040, 1);
      cycle();
      chk_eq("t4_req_pulse1", {63'd0, last_req}, 64'd0);
      cycle();
      chk_eq("t4_req_pulse2", {63'd0, last_req}, 64'd0);
      cycle();
      chk_eq("t4_req_resume", {63'd0, last_req}, 64'd1);
      cycle();
      chk_eq("t4_no_valid", {63'd0, valid_seen}, 64'd0);
      p0 = n_pops;
      drain("t4_drain", 20);
      chk_eq("t4_count", 64'(n_pops - p0), 64'd1);
      chk_eq("t4_pc", {32'h0, last_pop_pc}, 64'h3040);

      // Flush coinciding with the only outstanding response
      mem_stall = 1'b1;
      set_fetch(32'h0000_3300, 1);
      cycle();
      chk_eq("t5_pend", 64'(dut.pend_q), 64'd1);
      mem_stall = 1'b0;
      Flush = 1'b1;
      cycle();
      Flush = 1'b0;
      chk_eq("t5_drop", 64'(dut.drop_q), 64'd0);
      chk_eq("t5_pend0", 64'(dut.pend_q), 64'd0);
      set_fetch(32'h0000_3304, 1);
      cycle();
      chk_eq("t5_req", {63'd0, last_req}, 64'd1);
      drain("t5_drain", 20);
      chk_eq("t5_pc", {32'h0, last_pop_pc}, 64'h3304);

      // Asynchronous reset mid-stream
      set_fetch(32'h0000_3400, 8);
      cycle();
      cycle();
      cycle();
      ReSet_n = 1'b0;
      #1;
      chk_eq("t6_imemreq", {63'd0, ImemReq}, 64'd0);
      chk_eq("t6_pcready", {63'd0, PcReady}, 64'd0);
      chk_eq("t6_instrvalid", {63'd0, InstrValid}, 64'd0);
      chk_eq("t6_instr", {32'h0, Instr}, 64'd0);
      chk_eq("t6_instrpc", {32'h0, InstrPC}, 64'd0);
      chk_eq("t6_counters", 64'({dut.occ_q, dut.pend_q, dut.drop_q}), 64'd0);
      mem_q.delete();
      exp_q.delete();
      ImemRvalid = 1'b0;
      set_fetch(32'h0000_3000, 0);
      cycle();
      cycle();
      ReSet_n = 1'b1;
      p0 = n_pops;
      set_fetch(32'h0000_3000, 2);
      drain("t6_drain", 20);
      chk_eq("t6_count", 64'(n_pops - p0), 64'd2);
      chk_eq("t6_pc", {32'h0, last_pop_pc}, 64'h3004);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
